// File: rtl/rf_copy_engine.sv
// Register-file sequencer: block copy or element-wise add, one element per two cycles.
// Outputs are registered; rf_load alone is also gated combinationally by rst.
module rf_copy_engine (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        mode,
  input  logic [4:0]  src_a,
  input  logic [4:0]  src_b,
  input  logic [4:0]  dst,
  input  logic [5:0]  count,
  output logic        busy,
  output logic        done,
  output logic        rf_load,
  output logic [63:0] rf_din,
  output logic [4:0]  rf_Rw,
  output logic [4:0]  rf_Ra,
  output logic [4:0]  rf_Rb,
  output logic [4:0]  rf_offset,
  input  logic [63:0] rf_doutA,
  input  logic [63:0] rf_doutB
);

  typedef enum logic [1:0] {IDLE, READ, WRITE, FIN} state_t;

  state_t      state;
  logic        mode_q;
  logic [4:0]  sa_q;
  logic [4:0]  sb_q;
  logic [4:0]  dst_q;
  logic [5:0]  cnt_q;
  logic [5:0]  idx;
  logic        busy_q;
  logic        done_q;
  logic        load_q;
  logic [63:0] din_q;
  logic [4:0]  rw_q;
  logic [4:0]  ra_q;
  logic [4:0]  rb_q;
  logic [5:0]  cnt_clamp;
  logic [4:0]  idx_next;

  assign cnt_clamp = (count > 6'd32) ? 6'd32 : count;
  assign idx_next  = idx[4:0] + 5'd1;

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      mode_q <= 1'b0;
      sa_q   <= '0;
      sb_q   <= '0;
      dst_q  <= '0;
      cnt_q  <= '0;
      idx    <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      load_q <= 1'b0;
      din_q  <= '0;
      rw_q   <= '0;
      ra_q   <= '0;
      rb_q   <= '0;
    end else begin
      done_q <= 1'b0;
      load_q <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            mode_q <= mode;
            sa_q   <= src_a;
            sb_q   <= src_b;
            dst_q  <= dst;
            cnt_q  <= cnt_clamp;
            idx    <= '0;
            if (cnt_clamp == 6'd0) begin
              state  <= FIN;
              done_q <= 1'b1;
            end else begin
              state  <= READ;
              busy_q <= 1'b1;
              ra_q   <= src_a;
              rb_q   <= src_b;
            end
          end
        end
        READ: begin
          // Read data is combinational from ra_q/rb_q, so the result is ready this cycle.
          din_q  <= mode_q ? (rf_doutA + rf_doutB) : rf_doutA;
          rw_q   <= dst_q + idx[4:0];
          load_q <= 1'b1;
          state  <= WRITE;
        end
        WRITE: begin
          idx <= idx + 6'd1;
          if ((idx + 6'd1) == cnt_q) begin
            state  <= FIN;
            busy_q <= 1'b0;
            done_q <= 1'b1;
          end else begin
            state <= READ;
            ra_q  <= sa_q + idx_next;
            rb_q  <= sb_q + idx_next;
          end
        end
        FIN: begin
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign rf_load   = load_q & ~rst;
  assign rf_din    = din_q;
  assign rf_Rw     = rw_q;
  assign rf_Ra     = ra_q;
  assign rf_Rb     = rb_q;
  assign rf_offset = 5'd0;

endmodule

// File: tb/tb_rf_copy_engine.sv
// Bench for rf_copy_engine: behavioural RF plus a write scoreboard built from a sequential model.
module tb_rf_copy_engine;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        mode;
  logic [4:0]  src_a;
  logic [4:0]  src_b;
  logic [4:0]  dst;
  logic [5:0]  count;
  logic        busy;
  logic        done;
  logic        rf_load;
  logic [63:0] rf_din;
  logic [4:0]  rf_Rw;
  logic [4:0]  rf_Ra;
  logic [4:0]  rf_Rb;
  logic [4:0]  rf_offset;
  logic [63:0] rf_doutA;
  logic [63:0] rf_doutB;

  logic        tb_we;
  logic [4:0]  tb_wa;
  logic [63:0] tb_wd;
  logic [63:0] rf [32];

  typedef struct {
    logic [4:0]  a;
    logic [63:0] d;
  } wr_t;
  wr_t exp_q[$];

  int vecs = 0;
  int errs = 0;

  always #5 clk = ~clk;

  rf_copy_engine dut (
    .clk(clk), .rst(rst), .start(start), .mode(mode),
    .src_a(src_a), .src_b(src_b), .dst(dst), .count(count),
    .busy(busy), .done(done), .rf_load(rf_load), .rf_din(rf_din),
    .rf_Rw(rf_Rw), .rf_Ra(rf_Ra), .rf_Rb(rf_Rb), .rf_offset(rf_offset),
    .rf_doutA(rf_doutA), .rf_doutB(rf_doutB)
  );

  assign rf_doutA = rf[rf_Ra];
  assign rf_doutB = rf[rf_Rb];

  always @(posedge clk) begin
    if (rf_load) rf[rf_Rw] <= rf_din;
    else if (tb_we) rf[tb_wa] <= tb_wd;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Caller is at a negedge; returns at the next negedge.
  task automatic wr_rf(input logic [4:0] a, input logic [63:0] d);
    tb_we = 1'b1;
    tb_wa = a;
    tb_wd = d;
    @(negedge clk);
    tb_we = 1'b0;
  endtask

  task automatic run_cmd(input logic m, input logic [4:0] sa, input logic [4:0] sb,
                         input logic [4:0] d, input int cnt, input bit poke);
    logic [63:0] sh [32];
    logic [63:0] r;
    logic [4:0]  ia, ib, iw;
    wr_t         e;
    int          n, wr, dcyc;
    for (int i = 0; i < 32; i++) sh[i] = rf[i];
    n = (cnt > 32) ? 32 : cnt;
    for (int i = 0; i < n; i++) begin
      ia = sa + 5'(i);
      ib = sb + 5'(i);
      iw = d + 5'(i);
      r  = m ? (sh[ia] + sh[ib]) : sh[ia];
      exp_q.push_back('{iw, r});
      sh[iw] = r;
    end
    start = 1'b1; mode = m; src_a = sa; src_b = sb; dst = d; count = 6'(cnt);
    @(negedge clk);
    start = 1'b0;
    wr = 0;
    dcyc = 0;
    for (int c = 1; c <= 72 && dcyc == 0; c++) begin
      if (poke && c == 2) begin
        start = 1'b1; mode = ~m; src_a = sa + 5'd3; dst = d + 5'd7; count = 6'd1;
      end
      if (poke && c == 3) start = 1'b0;
      if (c == 1 && n > 0) chk("busy_first", busy, 1);
      if (rf_load) begin
        if (exp_q.size() == 0) chk("extra_write", rf_Rw, 5'h1f ^ rf_Rw);
        else begin
          e = exp_q.pop_front();
          chk("wr_addr", rf_Rw, e.a);
          chk("wr_data", rf_din, e.d);
        end
        wr++;
      end
      if (done) dcyc = c;
      if (dcyc == 0) @(negedge clk);
    end
    chk("done_cycle", dcyc, 2 * n + 1);
    chk("write_count", wr, n);
    chk("queue_empty", exp_q.size(), 0);
    exp_q.delete();
    @(negedge clk);
    chk("done_pulse", done, 0);
    chk("idle_busy", busy, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not reach its summary");
    $fatal(1);
  end

  initial begin
    int wcnt;
    rst = 1'b1; start = 1'b0; mode = 1'b0; src_a = '0; src_b = '0; dst = '0; count = '0;
    tb_we = 1'b0; tb_wa = '0; tb_wd = '0;
    @(negedge clk);

    // Reset: preload while reset is held, then two more reset cycles.
    wr_rf(5'd2, 64'd150);
    wr_rf(5'd3, 64'd7);
    wr_rf(5'd4, 64'hFFFF_FFFF_FFFF_FFFF);
    @(negedge clk);
    @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_load", rf_load, 0);
    chk("rst_din", rf_din, 0);
    chk("rst_rw", rf_Rw, 0);
    chk("rst_ra", rf_Ra, 0);
    chk("rst_rb", rf_Rb, 0);
    chk("rst_offset", rf_offset, 0);
    chk("rst_rf_keep", rf[4], 64'hFFFF_FFFF_FFFF_FFFF);
    rst = 1'b0;
    @(negedge clk);

    // Copy
    run_cmd(1'b0, 5'd2, 5'd0, 5'd20, 3, 1'b0);
    chk("copy_r20", rf[20], 64'd150);
    chk("copy_r21", rf[21], 64'd7);
    chk("copy_r22", rf[22], 64'hFFFF_FFFF_FFFF_FFFF);

    // Add with source wrap and discarded carry
    wr_rf(5'd30, 64'd1);
    wr_rf(5'd31, 64'hFFFF_FFFF_FFFF_FFFF);
    wr_rf(5'd0, 64'd5);
    wr_rf(5'd10, 64'd2);
    wr_rf(5'd11, 64'd1);
    wr_rf(5'd12, 64'd6);
    run_cmd(1'b1, 5'd30, 5'd10, 5'd14, 3, 1'b0);
    chk("add_r14", rf[14], 64'd3);
    chk("add_r15", rf[15], 64'd0);
    chk("add_r16", rf[16], 64'd11);

    // count = 0
    run_cmd(1'b0, 5'd1, 5'd0, 5'd5, 0, 1'b0);

    // Overlap, with an ignored start pulse mid-command
    wr_rf(5'd5, 64'd9);
    wr_rf(5'd6, 64'd1);
    wr_rf(5'd7, 64'd2);
    wr_rf(5'd8, 64'd3);
    run_cmd(1'b0, 5'd5, 5'd0, 5'd6, 3, 1'b1);
    chk("ovl_r6", rf[6], 64'd9);
    chk("ovl_r7", rf[7], 64'd9);
    chk("ovl_r8", rf[8], 64'd9);

    // count = 40 clamps to 32; destination wraps past 31
    for (int i = 0; i < 32; i++) wr_rf(5'(i), {$urandom(), $urandom()});
    run_cmd(1'b1, 5'd0, 5'd16, 5'd10, 40, 1'b0);

    // Reset during the third WRITE of an 8-element copy
    wr_rf(5'd0, 64'h11);
    wr_rf(5'd1, 64'h22);
    wr_rf(5'd2, 64'h33);
    wr_rf(5'd26, 64'hdead);
    start = 1'b1; mode = 1'b0; src_a = 5'd0; dst = 5'd24; count = 6'd8;
    @(negedge clk);
    start = 1'b0;
    wcnt = 0;
    for (int c = 1; c <= 5; c++) begin
      if (rf_load) begin
        wcnt++;
        chk("ab_wr_addr", rf_Rw, (c == 2) ? 5'd24 : 5'd25);
        chk("ab_wr_data", rf_din, (c == 2) ? 64'h11 : 64'h22);
      end
      @(negedge clk);
    end
    chk("ab_in_write", rf_load, 1);
    rst = 1'b1;
    #1;
    chk("ab_load_gated", rf_load, 0);
    @(negedge clk);
    rst = 1'b0;
    chk("ab_busy", busy, 0);
    chk("ab_done", done, 0);
    @(negedge clk);
    chk("ab_no_done", done, 0);
    chk("ab_writes", wcnt, 2);
    chk("ab_r25", rf[25], 64'h22);
    chk("ab_r26_kept", rf[26], 64'hdead);

    // Engine accepts a new command right after the abort
    run_cmd(1'b0, 5'd3, 5'd0, 5'd7, 1, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule

// File: doc/rf_copy_engine.md
# rf_copy_engine

Sequencing master for the 32 x 64-bit register file (RF). On a start pulse it walks a block of registers, reading source operands through RF ports A/B and writing results back through the write port, one element every two cycles. It supports a plain block copy and an element-wise add of two register blocks. It sits beside the datapath as a second RF initiator; the RF itself is unchanged.

## Interface

Parameters:
- none (RF geometry fixed: 32 registers, 64-bit data, 5-bit addresses)

Ports:
- clk  in  1  system clock; all state updates on rising edge
- rst  in  1  reset, synchronous, active-high
- start  in  1  command strobe, sampled only in IDLE
- mode  in  1  0 = copy (dst[i] = srcA[i]); 1 = add (dst[i] = srcA[i] + srcB[i])
- src_a  in  5  base register of operand block A
- src_b  in  5  base register of operand block B (ignored when mode=0)
- dst  in  5  base register of destination block
- count  in  6  number of elements, 0..32 (values above 32 are clamped to 32)
- busy  out  1  high while a command is executing
- done  out  1  one-cycle pulse when a command completes
- rf_load  out  1  RF write enable
- rf_din  out  64  RF write data
- rf_Rw  out  5  RF write address
- rf_Ra  out  5  RF read address, port A
- rf_Rb  out  5  RF read address, port B
- rf_offset  out  5  RF offset input; driven constant 0
- rf_doutA  in  64  RF read data, port A (combinational from rf_Ra)
- rf_doutB  in  64  RF read data, port B (combinational from rf_Rb)

## Operation

- States: IDLE, READ, WRITE, FIN.
- IDLE: busy=0, rf_load=0. When start=1, latch mode, src_a, src_b, dst, and the clamped count; clear the index. If count=0, go to FIN; otherwise go to READ.
- READ: busy=1. Drive rf_Ra = src_a+idx and rf_Rb = src_b+idx. Capture the result register at the clock edge: doutA (mode 0) or doutA+doutB (mode 1). Go to WRITE.
- WRITE: busy=1. Drive rf_load=1, rf_Rw = dst+idx, rf_din = the captured result. Increment idx. If idx+1 == count, go to FIN; otherwise go to READ.
- FIN: done=1, busy=0, rf_load=0. Go to IDLE.
- Address arithmetic is 5-bit and wraps modulo 32 (base 30, idx 3 addresses register 1).
- Add arithmetic is 64-bit unsigned. The carry-out is discarded.
- Ordering is strictly ascending idx. Overlapping blocks are not special-cased: each element is read immediately before its own write. Therefore dst = src_a+1 with count N propagates srcA[0] into all N destinations. This behaviour is defined and is tested.
- start during READ, WRITE, or FIN is ignored. No queueing.
- rf_offset is always 0. rf_Ra and rf_Rb hold their last values outside READ. rf_Rw and rf_din hold their values outside WRITE. Only rf_load qualifies a write.

## Timing

- Reset values, in the cycle after rst is sampled high: state IDLE, busy=0, done=0, rf_load=0, rf_din=0, rf_Rw=0, rf_Ra=0, rf_Rb=0, rf_offset=0, idx=0.
- rf_load is gated combinationally with !rst. A WRITE cycle coinciding with rst=1 performs no RF write. Reset mid-command abandons the command with no done pulse.
- start sampled at edge T:
  - First READ occupies cycle T+1; the first write commits at edge T+2.
  - Element k (0-based) is read in cycle T+1+2k and written in cycle T+2+2k.
  - done is high in cycle T+1+2N; IDLE is re-entered at T+2+2N.
  - count=0: done is high in cycle T+1, with no rf_load.
- Back-to-back commands: start may be asserted in the cycle IDLE is re-entered. The minimum command period is 2N+2 cycles.
- RF timing contract: read data is valid in the same cycle its address is driven; a write commits at the clock edge where rf_load=1.

## Test plan

- Reset: preload RF, assert rst for 2 cycles -> all outputs 0, busy=0, no rf_load, RF contents unchanged.
- Copy: R2=150, R3=7, R4=0xFFFF_FFFF_FFFF_FFFF; start mode=0 src_a=2 dst=20 count=3 -> R20=150, R21=7, R22=all-ones; exactly 3 rf_load pulses; done 7 cycles after start.
- Add with wrap and carry: R30=1, R31=0xFFFF_FFFF_FFFF_FFFF, R0=5; R10=2, R11=1, R12=6; start mode=1 src_a=30 src_b=10 dst=14 count=3 -> R14=3, R15=0, R16=11.
- Boundaries: count=0 -> done one cycle after start, no writes. count=40 -> treated as 32 (32 writes, done at +65), and dst wraps from 31 to 0.
- Overlap: R5=9, R6..R8 distinct; start mode=0 src_a=5 dst=6 count=3 -> R6=R7=R8=9.
- Reset and ignored start: start count=8, assert rst during the 3rd WRITE cycle -> that write is suppressed, no done pulse, IDLE the next cycle. Separately, pulse start while busy -> no effect on the running command.
